// File: rtl/powerup_timer_bank_if.sv
// Pickup/status bundle between the game logic and powerup_timer_bank.
// The game logic drives through master; the timer bank answers through slave.
interface powerup_timer_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned CNT_W  = 5
);
    logic                    eaten;
    logic [CH_W-1:0]         eaten_ch;
    logic [NUM_CH*CNT_W-1:0] dur_flat;
    logic                    stack_mode;
    logic                    pause;
    logic                    clear_all;
    logic [NUM_CH-1:0]       active;
    logic [NUM_CH-1:0]       warning;
    logic [NUM_CH-1:0]       expired;
    logic                    any_warning;
    logic [NUM_CH*CNT_W-1:0] remaining_flat;

    modport master (
        output eaten, eaten_ch, dur_flat, stack_mode, pause, clear_all,
        input  active, warning, expired, any_warning, remaining_flat
    );

    modport slave (
        input  eaten, eaten_ch, dur_flat, stack_mode, pause, clear_all,
        output active, warning, expired, any_warning, remaining_flat
    );
endinterface

// File: rtl/powerup_timer_bank.sv
// Bank of NUM_CH power-up countdown timers sharing one seconds prescaler.
// Pickups restart or stack a channel; status feeds paddle/ball logic and the HUD.
module powerup_timer_bank #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned PRESCALER = 64999999,
    parameter int unsigned WARN_SECS = 2
) (
    input logic                clk,
    input logic                reset,
    powerup_timer_bank_if.slave bus
);
    localparam int unsigned PS_W = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALER);

    logic [PS_W-1:0]   presc;
    logic              tick;
    logic [CNT_W-1:0]  rem      [NUM_CH];
    logic [CNT_W-1:0]  dur      [NUM_CH];
    logic [CNT_W:0]    sum      [NUM_CH];
    logic [CNT_W-1:0]  load_val [NUM_CH];
    logic [NUM_CH-1:0] load_hit;
    logic [NUM_CH-1:0] expired_q;

    assign tick = !bus.pause && (presc == PS_MAX);

    // Channel indices at or above NUM_CH never match a loop index, so such loads drop out.
    always_comb begin
        load_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            dur[i] = bus.dur_flat[i*CNT_W +: CNT_W];
            sum[i] = {1'b0, rem[i]} + {1'b0, dur[i]};
            if (!bus.stack_mode || rem[i] == '0)
                load_val[i] = dur[i];
            else if (sum[i][CNT_W])
                load_val[i] = '1;
            else
                load_val[i] = sum[i][CNT_W-1:0];
            load_hit[i] = bus.eaten && (bus.eaten_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            expired_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++)
                rem[i] <= '0;
        end else begin
            expired_q <= '0;
            if (bus.clear_all) begin
                presc <= '0;
                for (int unsigned i = 0; i < NUM_CH; i++)
                    rem[i] <= '0;
            end else begin
                if (!bus.pause)
                    presc <= tick ? '0 : presc + 1'b1;
                // A load on a channel swallows that channel's tick in the same cycle.
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (load_hit[i]) begin
                        rem[i] <= load_val[i];
                    end else if (tick && rem[i] != '0) begin
                        rem[i] <= rem[i] - 1'b1;
                        if (rem[i] == CNT_W'(1))
                            expired_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.active         = '0;
        bus.warning        = '0;
        bus.remaining_flat = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.active[i]  = (rem[i] != '0);
            bus.warning[i] = (rem[i] != '0) && (32'(rem[i]) <= WARN_SECS);
            bus.remaining_flat[i*CNT_W +: CNT_W] = rem[i];
        end
    end

    assign bus.expired     = expired_q;
    assign bus.any_warning = |bus.warning;
endmodule

// File: tb/tb_powerup_timer_bank.sv
// Directed bench for powerup_timer_bank with PRESCALER=3 (tick on every 4th edge).
// A 4-channel bank carries the main sequence; a 3-channel bank covers the unused index.
module tb_powerup_timer_bank;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    powerup_timer_bank_if #(.NUM_CH(4), .CH_W(2), .CNT_W(5)) bus4 ();
    powerup_timer_bank_if #(.NUM_CH(3), .CH_W(2), .CNT_W(5)) bus3 ();

    powerup_timer_bank #(
        .NUM_CH(4), .CH_W(2), .CNT_W(5), .PRESCALER(3), .WARN_SECS(2)
    ) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave)
    );

    powerup_timer_bank #(
        .NUM_CH(3), .CH_W(2), .CNT_W(5), .PRESCALER(3), .WARN_SECS(2)
    ) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] rem4(input int unsigned ch);
        return bus4.remaining_flat[ch*5 +: 5];
    endfunction

    task automatic load4(input logic [1:0] ch, input logic [4:0] dur, input logic stk);
        bus4.eaten            = 1'b1;
        bus4.eaten_ch         = ch;
        bus4.dur_flat[ch*5 +: 5] = dur;
        bus4.stack_mode       = stk;
    endtask

    // Edges are numbered Pk; the checks sit on the negedge Nk just after Pk.
    initial begin
        reset = 1'b1;
        bus4.eaten = 1'b0; bus4.eaten_ch = '0; bus4.dur_flat = '0;
        bus4.stack_mode = 1'b0; bus4.pause = 1'b0; bus4.clear_all = 1'b0;
        bus3.eaten = 1'b0; bus3.eaten_ch = '0; bus3.dur_flat = '0;
        bus3.stack_mode = 1'b0; bus3.pause = 1'b0; bus3.clear_all = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_active",  32'(bus4.active), 32'h0);
        check("rst_warning", 32'(bus4.warning), 32'h0);
        check("rst_expired", 32'(bus4.expired), 32'h0);
        check("rst_anywarn", 32'(bus4.any_warning), 32'h0);
        check("rst_remain",  32'(bus4.remaining_flat), 32'h0);

        // N0
        reset = 1'b0;
        load4(2'd1, 5'd3, 1'b0);
        bus3.eaten = 1'b1; bus3.eaten_ch = 2'd3; bus3.dur_flat = {3{5'd5}};
        @(negedge clk); // N1
        bus4.eaten = 1'b0; bus3.eaten = 1'b0;
        check("load_active", 32'(bus4.active), 32'h2);
        check("load_rem1",   32'(rem4(1)), 32'd3);
        check("load_warn",   32'(bus4.warning), 32'h0);
        check("oor_active",  32'(bus3.active), 32'h0);
        check("oor_remain",  32'(bus3.remaining_flat), 32'h0);
        bus3.eaten = 1'b1; bus3.eaten_ch = 2'd2;
        @(negedge clk); // N2
        bus3.eaten = 1'b0;
        check("ch3_last_active", 32'(bus3.active), 32'h4);
        check("ch3_last_remain", 32'(bus3.remaining_flat), {17'd0, 5'd5, 10'd0});
        @(negedge clk); // N3
        check("cd_pre_tick", 32'(rem4(1)), 32'd3);
        @(negedge clk); // N4
        check("cd_rem_2",    32'(rem4(1)), 32'd2);
        check("cd_warn_2",   32'(bus4.warning), 32'h2);
        check("cd_anywarn",  32'(bus4.any_warning), 32'h1);
        repeat (3) @(negedge clk); // N7
        check("cd_hold_2",   32'(rem4(1)), 32'd2);
        @(negedge clk); // N8
        check("cd_rem_1",    32'(rem4(1)), 32'd1);
        check("cd_warn_1",   32'(bus4.warning), 32'h2);
        repeat (3) @(negedge clk); // N11
        check("cd_no_early_exp", 32'(bus4.expired), 32'h0);
        @(negedge clk); // N12
        check("cd_rem_0",    32'(rem4(1)), 32'd0);
        check("cd_expired",  32'(bus4.expired), 32'h2);
        check("cd_inactive", 32'(bus4.active), 32'h0);
        check("cd_warn_off", 32'(bus4.warning), 32'h0);
        @(negedge clk); // N13
        check("cd_exp_once", 32'(bus4.expired), 32'h0);

        load4(2'd0, 5'd5, 1'b0);
        @(negedge clk); // N14
        bus4.eaten = 1'b0;
        check("rs_load5", 32'(rem4(0)), 32'd5);
        repeat (10) @(negedge clk); // N24
        check("rs_rem2", 32'(rem4(0)), 32'd2);
        load4(2'd0, 5'd5, 1'b0);
        @(negedge clk); // N25
        check("rs_restart", 32'(rem4(0)), 32'd5);
        load4(2'd0, 5'd30, 1'b1);
        @(negedge clk); // N26
        check("rs_stack_sat", 32'(rem4(0)), 32'd31);
        load4(2'd0, 5'd5, 1'b0);
        @(negedge clk); // N27
        check("rs_restart2", 32'(rem4(0)), 32'd5);
        load4(2'd0, 5'd4, 1'b1); // lands on tick edge P28
        @(negedge clk); // N28
        check("rs_stack_sum", 32'(rem4(0)), 32'd9);
        load4(2'd0, 5'd0, 1'b0);
        @(negedge clk); // N29
        check("cancel_active",  32'(bus4.active), 32'h0);
        check("cancel_expired", 32'(bus4.expired), 32'h0);
        load4(2'd2, 5'd2, 1'b0);
        @(negedge clk); // N30
        load4(2'd3, 5'd4, 1'b0);
        @(negedge clk); // N31
        bus4.eaten = 1'b0;
        check("lt_rem3_load", 32'(rem4(3)), 32'd4);
        @(negedge clk); // N32
        check("lt_rem2_1", 32'(rem4(2)), 32'd1);
        check("lt_rem3_3", 32'(rem4(3)), 32'd3);
        check("lt_warn",   32'(bus4.warning), 32'h4);
        repeat (3) @(negedge clk); // N35
        load4(2'd2, 5'd4, 1'b0); // lands on tick edge P36
        @(negedge clk); // N36
        bus4.eaten = 1'b0;
        check("lt_rem2_load", 32'(rem4(2)), 32'd4);
        check("lt_rem3_dec",  32'(rem4(3)), 32'd2);
        check("lt_no_exp",    32'(bus4.expired), 32'h0);
        check("lt_warn2",     32'(bus4.warning), 32'h8);

        @(negedge clk); // N37
        bus4.pause = 1'b1;
        repeat (10) @(negedge clk); // N47
        check("ps_mid_rem2", 32'(rem4(2)), 32'd4);
        check("ps_mid_rem3", 32'(rem4(3)), 32'd2);
        repeat (10) @(negedge clk); // N57
        check("ps_end_rem2", 32'(rem4(2)), 32'd4);
        check("ps_end_rem3", 32'(rem4(3)), 32'd2);
        bus4.pause = 1'b0;
        repeat (2) @(negedge clk); // N59
        check("ps_phase_hold", 32'(rem4(2)), 32'd4);
        @(negedge clk); // N60
        check("ps_phase_rem2", 32'(rem4(2)), 32'd3);
        check("ps_phase_rem3", 32'(rem4(3)), 32'd1);
        load4(2'd1, 5'd6, 1'b0);
        @(negedge clk); // N61
        check("ca_rem1_pre", 32'(rem4(1)), 32'd6);
        load4(2'd0, 5'd5, 1'b0);
        bus4.clear_all = 1'b1;
        @(negedge clk); // N62
        bus4.clear_all = 1'b0;
        check("ca_active",  32'(bus4.active), 32'h0);
        check("ca_remain",  32'(bus4.remaining_flat), 32'h0);
        check("ca_expired", 32'(bus4.expired), 32'h0);
        load4(2'd0, 5'd1, 1'b0);
        @(negedge clk); // N63
        bus4.eaten = 1'b0;
        check("ca_expired2", 32'(bus4.expired), 32'h0);
        check("ca_reload",   32'(rem4(0)), 32'd1);
        repeat (2) @(negedge clk); // N65
        check("ca_presc_zeroed", 32'(rem4(0)), 32'd1);
        @(negedge clk); // N66
        check("ca_tick_rem0", 32'(rem4(0)), 32'd0);
        check("ca_tick_exp",  32'(bus4.expired), 32'h1);

        load4(2'd1, 5'd1, 1'b0);
        @(negedge clk); // N67
        bus4.eaten = 1'b0;
        repeat (2) @(negedge clk); // N69
        check("mr_rem1", 32'(rem4(1)), 32'd1);
        reset = 1'b1;
        @(negedge clk); // N70
        reset = 1'b0;
        check("mr_active",  32'(bus4.active), 32'h0);
        check("mr_expired", 32'(bus4.expired), 32'h0);
        check("mr_remain",  32'(bus4.remaining_flat), 32'h0);
        check("mr_anywarn", 32'(bus4.any_warning), 32'h0);
        @(negedge clk); // N71
        check("mr_expired2", 32'(bus4.expired), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/powerup_timer_bank.md
Name: powerup_timer_bank

Overview:
Parametrised bank of NUM_CH independent power-up countdown timers driven by one shared seconds prescaler. A game-logic pickup event loads one channel with a per-channel duration, either restarting it or stacking onto the time left. The bank reports per-channel active, warning and expiry status to the paddle and ball logic. It adds pause, clear-all and a readable remaining-seconds value for the on-screen HUD.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
CH_W, 2, width of channel index; must satisfy 2**CH_W >= NUM_CH
CNT_W, 5, width of each remaining-seconds counter; maximum value is 2**CNT_W-1
PRESCALER, 64999999, clk cycles per second minus 1; one tick every PRESCALER+1 cycles
WARN_SECS, 2, warning asserted while 1 <= remaining <= WARN_SECS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
eaten  in  1  single-cycle pickup strobe
eaten_ch  in  CH_W  channel to load when eaten=1
dur_flat  in  NUM_CH*CNT_W  per-channel load duration in seconds; channel i uses bits [i*CNT_W +: CNT_W]
stack_mode  in  1  0 = reload replaces remaining time; 1 = reload adds to remaining time
pause  in  1  level; freezes the prescaler and all counters
clear_all  in  1  single-cycle strobe; cancels all channels
active  out  NUM_CH  channel i remaining != 0
warning  out  NUM_CH  channel i active and remaining <= WARN_SECS
expired  out  NUM_CH  one-cycle pulse when channel i counts down to 0
any_warning  out  1  OR of warning
remaining_flat  out  NUM_CH*CNT_W  registered remaining seconds per channel

Behaviour:
- Reset: prescaler=0, all remaining=0, so active=0, warning=0, expired=0 and any_warning=0. This applies on the first cycle after reset is sampled high, regardless of any operation in progress.
- Prescaler: counts 0..PRESCALER and wraps to 0. tick=1 in the cycle where prescaler==PRESCALER and pause=0.
- Pause: while pause=1 the prescaler holds and no tick occurs. Loads and clear_all still take effect during pause.
- Because the prescaler is shared, the first decrement after a load happens 1..PRESCALER+1 cycles later. The bank makes no per-channel phase alignment.
- Tick: every channel with remaining!=0 decrements by 1. Channels already at 0 stay at 0 and do not wrap.
- Load: when eaten=1 and eaten_ch<NUM_CH, channel c=eaten_ch is loaded.
  - If stack_mode=0 or remaining[c]==0, remaining[c] <= dur[c].
  - Otherwise remaining[c] <= min(remaining[c]+dur[c], 2**CNT_W-1). Compute the sum at CNT_W+1 bits and saturate.
  - eaten_ch>=NUM_CH: the load is ignored.
  - dur[c]==0 with stack_mode=0 cancels the channel silently, with no expired pulse.
- Load and tick in the same cycle on the same channel: the load wins and the tick is dropped for that channel only. Other channels still decrement.
- clear_all: all remaining become 0 and the prescaler becomes 0. No expired pulses are generated. It takes priority over a simultaneous eaten.
- expired[i] is registered. It pulses exactly one cycle, in the cycle after a tick moves remaining[i] from 1 to 0. It is never asserted by a load, clear_all or reset.
- active, warning and remaining_flat are combinational from the remaining registers, so they update one cycle after the eaten, tick or clear_all edge. Latency from eaten to active is 1 cycle.
- warning never asserts when remaining==0. With WARN_SECS=0, warning is constant 0.

Test Plan (PRESCALER=3, NUM_CH=4, CNT_W=5, WARN_SECS=2):
- Basic countdown: reset, then eaten with ch=1, dur1=3.
  - Required: active=4'b0010 the next cycle; remaining1 reads 3,2,1,0 on successive ticks 4 cycles apart.
  - warning[1] high while remaining1 is 2 or 1; expired[1] pulses exactly once; active[1] drops together with the pulse.
- Restart vs stack: ch0 has dur0=5 and remaining0=2.
  - eaten with stack_mode=0 -> remaining0=5.
  - eaten with stack_mode=1 and dur0=30 -> remaining0=31, saturated.
- Simultaneous load and tick: issue eaten ch2 (dur2=4) in a tick cycle while remaining2=1 and remaining3=3.
  - Required: remaining2=4, remaining3=2, no expired[2] pulse.
- Pause: assert pause for 20 cycles mid-count.
  - Required: remaining values and prescaler frozen, no ticks.
  - After release, the next tick arrives at the same prescaler phase as before the pause.
- clear_all together with eaten ch0 while ch1 and ch3 are active.
  - Required: all remaining=0 and expired=0 next cycle; ch0 not loaded.
- Out-of-range index and reset: with NUM_CH=3, eaten_ch=3 -> no change.
  - Reset asserted mid-count -> all outputs 0 the next cycle; no expired pulse.
